// File: rtl/sgm_video_pkg.sv
// Shared constants for the SGM video path: disparity width, filter latency,
// and a constant-evaluable ceil(log2) used for RAM address sizing.
package sgm_video_pkg;

    localparam int PIX_BITS = 8;
    localparam int LATENCY  = 5;

    // Returns at least 1 so a single-entry RAM still gets a legal address width.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/median9_pipe.sv
// Three-stage pipelined 19-exchange median-of-9 with valid/bypass sideband.
// Only the valid bits are reset; the data path is free-running.
module median9_pipe
    import sgm_video_pkg::*;
#(
    parameter int W = PIX_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_in,
    input  logic              byp_in,
    input  logic [8:0][W-1:0] win_in,
    output logic              vld_out,
    output logic [W-1:0]      pix_out
);

    typedef logic [8:0][W-1:0] vec9_t;

    // Compare-exchange: smaller value ends up at index a.
    function automatic vec9_t cx(input vec9_t v, input logic [3:0] a, input logic [3:0] b);
        vec9_t r;
        r = v;
        if (v[a] > v[b]) begin
            r[a] = v[b];
            r[b] = v[a];
        end
        return r;
    endfunction

    vec9_t          s1_d, s1_q, s2_d, s2_q, s3_t;
    logic [W-1:0]   s3_d, ctr1, ctr2;
    logic [3:1]     vld_pipe;
    logic [2:1]     byp_pipe;

    // Stage 1 sorts each triple of the window.
    always_comb begin
        s1_d = win_in;
        s1_d = cx(s1_d, 4'd1, 4'd2); s1_d = cx(s1_d, 4'd4, 4'd5); s1_d = cx(s1_d, 4'd7, 4'd8);
        s1_d = cx(s1_d, 4'd0, 4'd1); s1_d = cx(s1_d, 4'd3, 4'd4); s1_d = cx(s1_d, 4'd6, 4'd7);
        s1_d = cx(s1_d, 4'd1, 4'd2); s1_d = cx(s1_d, 4'd4, 4'd5); s1_d = cx(s1_d, 4'd7, 4'd8);
    end

    always_comb begin
        s2_d = s1_q;
        s2_d = cx(s2_d, 4'd0, 4'd3); s2_d = cx(s2_d, 4'd5, 4'd8); s2_d = cx(s2_d, 4'd4, 4'd7);
        s2_d = cx(s2_d, 4'd3, 4'd6); s2_d = cx(s2_d, 4'd1, 4'd4); s2_d = cx(s2_d, 4'd2, 4'd5);
    end

    always_comb begin
        s3_t = s2_q;
        s3_t = cx(s3_t, 4'd4, 4'd7); s3_t = cx(s3_t, 4'd4, 4'd2);
        s3_t = cx(s3_t, 4'd6, 4'd4); s3_t = cx(s3_t, 4'd4, 4'd2);
        s3_d = byp_pipe[2] ? ctr2 : s3_t[4];
    end

    always_ff @(posedge clk) begin
        s1_q     <= s1_d;
        s2_q     <= s2_d;
        pix_out  <= s3_d;
        ctr1     <= win_in[4];
        ctr2     <= ctr1;
        byp_pipe <= {byp_pipe[1], byp_in};
    end

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[2:1], vld_in};
    end

    assign vld_out = vld_pipe[3];

endmodule

// File: rtl/disparity_median_filter.sv
// Streaming 3x3 median on the SGM disparity stream: two line buffers, a 3x3
// window and a 3-stage sorter, with video timing delayed to match.
module disparity_median_filter
    import sgm_video_pkg::*;
#(
    parameter int IMG_WIDTH = 1280,
    parameter int ROW_WIDTH = 10,
    parameter int COL_WIDTH = 11,
    parameter int PIX_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                de_in,
    input  logic                h_sync_in,
    input  logic                v_sync_in,
    input  logic                bypass_in,
    input  logic [PIX_BITS-1:0] pixel_disparity_in,
    output logic                clk_out,
    output logic                de_out,
    output logic                h_sync_out,
    output logic                v_sync_out,
    output logic [PIX_BITS-1:0] pixel_out
);

    localparam int                   AW      = clog2(IMG_WIDTH);
    localparam logic [COL_WIDTH-1:0] COL_END = COL_WIDTH'(IMG_WIDTH);
    localparam logic [ROW_WIDTH-1:0] ROW_MAX = '1;

    logic [ROW_WIDTH-1:0]  row;
    logic [COL_WIDTH-1:0]  col;
    logic                  de_prev, vs_prev, de_fall, vs_rise, wr_en;
    logic [AW-1:0]         addr;
    logic [PIX_BITS-1:0]   lb0 [IMG_WIDTH];
    logic [PIX_BITS-1:0]   lb1 [IMG_WIDTH];
    logic [PIX_BITS-1:0]   rd0, rd1, pix_d;
    logic                  de_d1, vld1, byp1, win_vld, win_byp;
    logic [2:0][2:0][PIX_BITS-1:0] win;
    logic [LATENCY-1:0]    de_dly, hs_dly, vs_dly;
    logic                  med_vld;
    logic [PIX_BITS-1:0]   med_pix;

    assign de_fall = de_prev & ~de_in;
    assign vs_rise = v_sync_in & ~vs_prev;
    assign wr_en   = de_in && (col < COL_END);
    assign addr    = col[AW-1:0];

    // Line buffers: read-before-write shifts the old lb0 entry down into lb1.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb0[addr] <= pixel_disparity_in;
            lb1[addr] <= lb0[addr];
        end
        rd0   <= lb0[addr];
        rd1   <= lb1[addr];
        pix_d <= pixel_disparity_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row     <= '0;
            col     <= '0;
            de_prev <= 1'b0;
            vs_prev <= 1'b0;
            de_d1   <= 1'b0;
            vld1    <= 1'b0;
            byp1    <= 1'b0;
            win_vld <= 1'b0;
            win_byp <= 1'b0;
            win     <= '0;
            de_dly  <= '0;
            hs_dly  <= '0;
            vs_dly  <= '0;
        end else begin
            de_prev <= de_in;
            vs_prev <= v_sync_in;
            if (vs_rise)                       row <= '0;
            else if (de_fall && row != ROW_MAX) row <= row + 1'b1;
            if (de_fall)    col <= '0;
            else if (wr_en) col <= col + 1'b1;
            // Border decision is made on the newest pixel's coordinates.
            de_d1 <= de_in;
            vld1  <= wr_en && (row >= ROW_WIDTH'(2)) && (col >= COL_WIDTH'(2));
            byp1  <= bypass_in;
            if (de_d1) win <= {{pix_d, rd0, rd1}, win[2:1]};
            win_vld <= vld1 & de_d1;
            win_byp <= byp1;
            de_dly  <= {de_dly[LATENCY-2:0], de_in};
            hs_dly  <= {hs_dly[LATENCY-2:0], h_sync_in};
            vs_dly  <= {vs_dly[LATENCY-2:0], v_sync_in};
        end
    end

    median9_pipe #(.W(PIX_BITS)) u_median (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (win_vld),
        .byp_in  (win_byp),
        .win_in  (win),
        .vld_out (med_vld),
        .pix_out (med_pix)
    );

    assign clk_out    = clk;
    assign de_out     = de_dly[LATENCY-1];
    assign h_sync_out = hs_dly[LATENCY-1];
    assign v_sync_out = vs_dly[LATENCY-1];
    assign pixel_out  = med_vld ? med_pix : '0;

endmodule

// File: tb/tb_disparity_median_filter.sv
// Directed bench for disparity_median_filter on an 8-pixel-wide image; each
// step's expected outputs are queued and checked five cycles later.
module tb_disparity_median_filter;

    localparam int FLAT = 0, IMPULSE = 1, VRAMP = 2, SHUF = 3, HRAMP = 4;

    logic       clk = 1'b0;
    logic       rst, de_in, hs_in, vs_in, byp_in;
    logic [7:0] pix_in;
    logic       clk_out, de_out, hs_out, vs_out;
    logic [7:0] pix_out;

    int checks = 0;
    int errors = 0;
    int s = 0;

    logic       hde [4096];
    logic       hhs [4096];
    logic       hvs [4096];
    logic [7:0] hpx [4096];

    always #5 clk = ~clk;

    disparity_median_filter #(
        .IMG_WIDTH(8), .ROW_WIDTH(10), .COL_WIDTH(11), .PIX_BITS(8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .de_in              (de_in),
        .h_sync_in          (hs_in),
        .v_sync_in          (vs_in),
        .bypass_in          (byp_in),
        .pixel_disparity_in (pix_in),
        .clk_out            (clk_out),
        .de_out             (de_out),
        .h_sync_out         (hs_out),
        .v_sync_out         (vs_out),
        .pixel_out          (pix_out)
    );

    function automatic logic [7:0] pix_val(input int kind, input int val, input int r, input int c);
        logic [7:0] tile [9];
        tile = '{8'd7, 8'd1, 8'd8, 8'd0, 8'd4, 8'd2, 8'd6, 8'd3, 8'd5};
        case (kind)
            IMPULSE: return (r == 3 && c == 3) ? 8'd255 : 8'd10;
            VRAMP:   return 8'(r * 4);
            SHUF:    return tile[(r % 3) * 3 + (c % 3)];
            HRAMP:   return 8'(c * 3);
            default: return 8'(val);
        endcase
    endfunction

    // Hand-derived medians (or bypass centres) for a window whose newest pixel is (lr, lc).
    function automatic logic [7:0] exp_val(input int kind, input int val, input int lr, input int lc);
        if (lr < 2 || lc < 2) return 8'd0;
        case (kind)
            IMPULSE: return 8'd10;
            VRAMP:   return 8'((lr - 1) * 4);
            SHUF:    return 8'd4;
            HRAMP:   return 8'((lc - 1) * 3);
            default: return 8'(val);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (step %0d)", tag, obs, exp, s);
        end
    endtask

    task automatic step(input logic de, input logic hs, input logic vs, input logic byp,
                        input logic r, input logic [7:0] px, input logic [7:0] ex);
        rst    = r;
        de_in  = de;
        hs_in  = hs;
        vs_in  = vs;
        byp_in = byp;
        pix_in = px;
        if (s >= 4096) begin
            $display("FAIL step_budget: got %0d steps expected below 4096", s);
            $fatal(1, "step budget exhausted");
        end
        hde[s] = de;
        hhs[s] = hs;
        hvs[s] = vs;
        hpx[s] = de ? ex : 8'd0;
        // Reset flushes everything already in flight, including this step's input.
        if (r)
            for (int i = s - 4; i <= s; i++)
                if (i >= 0) begin
                    hde[i] = 1'b0; hhs[i] = 1'b0; hvs[i] = 1'b0; hpx[i] = 8'd0;
                end
        @(posedge clk);
        @(negedge clk);
        if (r) begin
            chk("rst_de_out", 8'(de_out), 8'd0);
            chk("rst_pixel_out", pix_out, 8'd0);
            chk("rst_syncs", 8'({hs_out, vs_out}), 8'd0);
        end
        if (s >= 4) begin
            chk("de_out", 8'(de_out), 8'(hde[s-4]));
            chk("h_sync_out", 8'(hs_out), 8'(hhs[s-4]));
            chk("v_sync_out", 8'(vs_out), 8'(hvs[s-4]));
            chk("pixel_out", pix_out, hpx[s-4]);
        end
        s++;
    endtask

    task automatic frame(input int kind, input int val, input int nrows, input logic byp,
                         input int rst_row, input int rst_col);
        int lr, lc;
        logic [7:0] px;
        step(0, 0, 1, 0, 0, 8'd0, 8'd0);
        step(0, 0, 1, 0, 0, 8'd0, 8'd0);
        step(0, 0, 0, 0, 0, 8'd0, 8'd0);
        step(0, 0, 0, 0, 0, 8'd0, 8'd0);
        lr = 0;
        for (int r = 0; r < nrows; r++) begin
            lc = 0;
            for (int c = 0; c < 8; c++) begin
                px = pix_val(kind, val, r, c);
                if (r == rst_row && c == rst_col) begin
                    step(1, 0, 0, byp, 1, px, 8'd0);
                    lr = 0;
                    lc = 0;
                end else begin
                    step(1, 0, 0, byp, 0, px, exp_val(kind, val, lr, lc));
                    lc++;
                end
            end
            step(0, 1, 0, 0, 0, 8'd0, 8'd0);
            step(0, 1, 0, 0, 0, 8'd0, 8'd0);
            for (int b = 0; b < 4; b++) step(0, 0, 0, 0, 0, 8'd0, 8'd0);
            lr++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            hde[i] = 1'b0; hhs[i] = 1'b0; hvs[i] = 1'b0; hpx[i] = 8'd0;
        end
        step(0, 0, 0, 0, 1, 8'd0, 8'd0);
        step(0, 0, 0, 0, 1, 8'd0, 8'd0);
        frame(FLAT,    20, 6, 1'b0, -1, -1);
        frame(IMPULSE,  0, 6, 1'b0, -1, -1);
        frame(VRAMP,    0, 6, 1'b0, -1, -1);
        frame(SHUF,     0, 6, 1'b0, -1, -1);
        frame(HRAMP,    0, 6, 1'b1, -1, -1);
        frame(FLAT,    50, 1, 1'b0, -1, -1);
        frame(FLAT,    30, 8, 1'b0,  4,  4);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 8'd0, 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
